// File: rtl/wb_dcache_mem_bridge_pkg.sv
// Shared types and derived geometry for the dcache <-> data-memory bridge.
package wb_dcache_mem_bridge_pkg;

  localparam int DCACHE_ADDR_W = 32;
  localparam int DCACHE_LINE_W = 128;
  localparam int DCACHE_BUS_W  = 32;

  // Number of bus beats needed to move one cache line.
  function automatic int line_beats(input int line_w, input int bus_w);
    return line_w / bus_w;
  endfunction

  // Number of byte-offset bits inside one cache line.
  function automatic int line_offset_bits(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  localparam int DCACHE_LINE_BEATS       = line_beats(DCACHE_LINE_W, DCACHE_BUS_W);
  localparam int DCACHE_LINE_OFFSET_BITS = line_offset_bits(DCACHE_LINE_W);

  typedef enum logic [1:0] {
    ST_IDLE,   // waiting for a line request
    ST_BEAT,   // issuing bus beats for the current line
    ST_DRAIN,  // request killed, waiting for the outstanding beat to retire
    ST_RESP    // line done, pulsing the ack back to the controller
  } type_dcache_bridge_states_e;

endpackage

// File: rtl/wb_dcache_mem_bridge.sv
// Line-to-beat sequencer: turns one dcache line request (refill or write-back)
// into LINE_W/BUS_W ascending bus beats and returns a single-cycle line ack.
module wb_dcache_mem_bridge
  import wb_dcache_mem_bridge_pkg::*;
#(
  parameter int ADDR_W = DCACHE_ADDR_W,
  parameter int LINE_W = DCACHE_LINE_W,
  parameter int BUS_W  = DCACHE_BUS_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dcache2mem_req_i,
  input  logic              dcache2mem_wr_i,
  input  logic              dcache2mem_kill_i,
  input  logic [ADDR_W-1:0] dcache2mem_addr_i,
  input  logic [LINE_W-1:0] dcache2mem_data_i,
  output logic              mem2dcache_ack_o,
  output logic [LINE_W-1:0] mem2dcache_data_o,
  output logic              bus_req_o,
  output logic              bus_wr_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [BUS_W-1:0]  bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [BUS_W-1:0]  bus_rdata_i
);

  localparam int BEATS      = line_beats(LINE_W, BUS_W);
  localparam int CNT_W      = $clog2(BEATS);
  localparam int BEAT_BYTES = BUS_W / 8;
  localparam int LINE_BYTES = LINE_W / 8;

  localparam logic [CNT_W-1:0]  LAST_BEAT   = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(LINE_BYTES - 1);

  type_dcache_bridge_states_e state;
  logic [CNT_W-1:0]           cnt;
  logic [LINE_W-1:0]          wline_q;   // write-back words not yet on the bus
  logic [ADDR_W-1:0]          line_base;

  // Line-aligned form of the incoming request address.
  assign line_base = dcache2mem_addr_i & ~OFFSET_MASK;

  // Sequencer: state, beat counter, write shift register and all registered outputs.
  // NOTE: every register here is assigned with <= so all of them update from the
  // same pre-edge values; a blocking = would let later statements see new values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      cnt               <= '0;
      wline_q           <= '0;
      mem2dcache_ack_o  <= 1'b0;
      // NOTE: the line data registers are reset too, because the refill line is
      // a visible output that must read as zero straight out of reset.
      mem2dcache_data_o <= '0;
      bus_req_o         <= 1'b0;
      bus_wr_o          <= 1'b0;
      bus_addr_o        <= '0;
      bus_wdata_o       <= '0;
    end else begin
      mem2dcache_ack_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          // Kill wins over a request arriving in the same cycle.
          if (dcache2mem_req_i && !dcache2mem_kill_i) begin
            cnt         <= '0;
            bus_req_o   <= 1'b1;
            bus_wr_o    <= dcache2mem_wr_i;
            bus_addr_o  <= line_base;
            bus_wdata_o <= dcache2mem_data_i[BUS_W-1:0];
            wline_q     <= dcache2mem_data_i >> BUS_W;
            state       <= ST_BEAT;
          end
        end
        ST_BEAT: begin
          if (bus_ack_i) begin
            // Read data is valid in the ack cycle; drop it into its beat slot.
            if (!bus_wr_o) begin
              mem2dcache_data_o[int'(cnt)*BUS_W +: BUS_W] <= bus_rdata_i;
            end
            cnt         <= cnt + CNT_W'(1);
            bus_addr_o  <= bus_addr_o + ADDR_W'(BEAT_BYTES);
            bus_wdata_o <= wline_q[BUS_W-1:0];
            wline_q     <= wline_q >> BUS_W;
            if (dcache2mem_kill_i) begin
              bus_req_o <= 1'b0;
              state     <= ST_IDLE;
            end else if (cnt == LAST_BEAT) begin
              bus_req_o        <= 1'b0;
              mem2dcache_ack_o <= 1'b1;
              state            <= ST_RESP;
            end
          end else if (dcache2mem_kill_i) begin
            // The bus cannot retract a beat, so keep requesting until it retires.
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_RESP: begin
          // The ack pulse is already up for this cycle; requests are not looked at here.
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_dcache_mem_bridge.sv
// Self-checking bench for wb_dcache_mem_bridge: a word-addressed memory model
// answers bus beats with random latency, and each line's expected beats, refill
// line and ack timing are derived from the request alone.
module tb_wb_dcache_mem_bridge;
  import wb_dcache_mem_bridge_pkg::*;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;
  localparam int BUS_W  = 32;

  logic              clk;
  logic              rst_n;
  logic              req;
  logic              wr;
  logic              kill;
  logic [ADDR_W-1:0] addr;
  logic [LINE_W-1:0] data;
  logic              mem2dcache_ack_o;
  logic [LINE_W-1:0] mem2dcache_data_o;
  logic              bus_req_o;
  logic              bus_wr_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [BUS_W-1:0]  bus_wdata_o;
  logic              bus_ack;
  logic [BUS_W-1:0]  bus_rdata;

  wb_dcache_mem_bridge #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BUS_W(BUS_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .dcache2mem_req_i  (req),
    .dcache2mem_wr_i   (wr),
    .dcache2mem_kill_i (kill),
    .dcache2mem_addr_i (addr),
    .dcache2mem_data_i (data),
    .mem2dcache_ack_o  (mem2dcache_ack_o),
    .mem2dcache_data_o (mem2dcache_data_o),
    .bus_req_o         (bus_req_o),
    .bus_wr_o          (bus_wr_o),
    .bus_addr_o        (bus_addr_o),
    .bus_wdata_o       (bus_wdata_o),
    .bus_ack_i         (bus_ack),
    .bus_rdata_i       (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;
  int ack_pulses = 0;

  logic [31:0]       mem_model [logic [31:0]];
  logic [31:0]       salt;
  logic [LINE_W-1:0] model_data;   // what the refill line output should currently hold

  // Count every cycle in which the line ack is high.
  always @(posedge clk) if (mem2dcache_ack_o === 1'b1) ack_pulses++;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  // One bus beat: hold off the ack for w cycles (outputs must stay put), then ack.
  task automatic drive_beat(input logic wr_b, input logic [31:0] base, input logic [LINE_W-1:0] line,
                            input int b, input int w, input bit kill_at_ack, input string name);
    logic [66:0] exp_o;
    logic [66:0] obs;
    logic [31:0] a;
    a = base + 32'(b * 4);
    exp_o = {1'b1, wr_b, a, wr_b ? line[b*32 +: 32] : 32'h0, 1'b0};
    for (int c = 0; c <= w; c++) begin
      obs = {bus_req_o, bus_wr_o, bus_addr_o, wr_b ? bus_wdata_o : 32'h0, mem2dcache_ack_o};
      n_run++;
      if (obs !== exp_o) begin
        n_fail++;
        $display("FAIL %s beat%0d cyc%0d {req,wr,addr,wdata,ack}: got %h expected %h", name, b, c, obs, exp_o);
      end
      if (c == w) begin
        bus_ack = 1'b1;
        if (kill_at_ack) begin kill = 1'b1; req = 1'b0; end
        if (wr_b) mem_model[a] = line[b*32 +: 32];
        else begin
          bus_rdata = mem_read(a);
          model_data[b*32 +: 32] = bus_rdata;
        end
      end else begin
        bus_ack   = 1'b0;
        bus_rdata = $urandom;
      end
      @(negedge clk);
    end
    bus_ack   = 1'b0;
    kill      = 1'b0;
    bus_rdata = $urandom;
  endtask

  // Full line transfer; lat < 0 picks a random 0..3 wait per beat.
  task automatic run_line(input logic wr_l, input logic [31:0] a, input logic [LINE_W-1:0] line,
                          input int lat, input bit keep_req, input bit drop_early, input string name);
    logic [31:0]       base;
    logic [LINE_W+1:0] obs;
    logic [LINE_W+1:0] exp_r;
    base = a & ~32'hF;
    req = 1'b1; wr = wr_l; addr = a; data = line; kill = 1'b0;
    @(negedge clk);
    if (drop_early) req = 1'b0;
    for (int b = 0; b < DCACHE_LINE_BEATS; b++)
      drive_beat(wr_l, base, line, b, (lat < 0) ? int'($urandom_range(0, 3)) : lat, 1'b0, name);
    obs   = {bus_req_o, mem2dcache_ack_o, mem2dcache_data_o};
    exp_r = {1'b0, 1'b1, model_data};
    n_run++;
    if (obs !== exp_r) begin
      n_fail++;
      $display("FAIL %s resp {bus_req,ack,data}: got %h expected %h", name, obs, exp_r);
    end
    if (!keep_req) begin
      req = 1'b0;
      @(negedge clk);
      n_run++;
      if ({bus_req_o, mem2dcache_ack_o} !== 2'b00) begin
        n_fail++;
        $display("FAIL %s after-ack {bus_req,ack}: got %b expected 00", name, {bus_req_o, mem2dcache_ack_o});
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; wr = 1'b0; kill = 1'b0; addr = '0; data = '0;
    bus_ack = 1'b0; bus_rdata = '0; model_data = '0;
    #12;
    n_run++;
    if ({mem2dcache_ack_o, mem2dcache_data_o, bus_req_o, bus_wr_o, bus_addr_o, bus_wdata_o} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: got ack=%b data=%h req=%b wr=%b addr=%h wdata=%h expected all 0",
               mem2dcache_ack_o, mem2dcache_data_o, bus_req_o, bus_wr_o, bus_addr_o, bus_wdata_o);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_run++;
    if ({bus_req_o, mem2dcache_ack_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset idle: got %b expected 00", {bus_req_o, mem2dcache_ack_o});
    end
  endtask

  task automatic test_refill_directed();
    run_line(1'b0, 32'h8000_0014, {$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, 1'b0, "refill_8000_0014");
  endtask

  task automatic test_writeback_directed();
    run_line(1'b1, 32'h0000_0100, 128'h00004444_00003333_00002222_00001111, 2, 1'b0, 1'b0, "wb_0100");
    // Read the line back through a refill: the memory model now holds the written words.
    run_line(1'b0, 32'h0000_0108, {$urandom, $urandom, $urandom, $urandom}, 1, 1'b0, 1'b0, "readback_0100");
  endtask

  task automatic test_random_lines();
    logic [31:0] a;
    for (int i = 0; i < 16; i++) begin
      a = 32'h0000_1000 + 32'($urandom_range(0, 7)) * 32'd16 + 32'($urandom_range(0, 15));
      run_line(1'($urandom_range(0, 1)), a, {$urandom, $urandom, $urandom, $urandom}, -1,
               1'b0, 1'($urandom_range(0, 1)), "rand");
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = ack_pulses;
    run_line(1'b1, 32'h0000_2040, {$urandom, $urandom, $urandom, $urandom}, 0, 1'b1, 1'b0, "b2b_wb");
    wr = 1'b0; addr = 32'h0000_2044;
    @(negedge clk);
    n_run++;
    if ({bus_req_o, mem2dcache_ack_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b bubble {bus_req,ack}: got %b expected 00", {bus_req_o, mem2dcache_ack_o});
    end
    run_line(1'b0, 32'h0000_2044, '0, 0, 1'b0, 1'b0, "b2b_refill");
    n_run++;
    if (ack_pulses - c0 !== 2) begin
      n_fail++;
      $display("FAIL b2b ack count: got %0d expected 2", ack_pulses - c0);
    end
  endtask

  task automatic test_kill_drain();
    int          c0;
    logic [31:0] base;
    logic [66:0] exp_o;
    logic [LINE_W+1:0] exp_r;
    c0 = ack_pulses;
    base = 32'h0000_3000;
    req = 1'b1; wr = 1'b0; addr = base + 32'h4; kill = 1'b0;
    @(negedge clk);
    drive_beat(1'b0, base, '0, 0, 0, 1'b0, "kill_drain");
    drive_beat(1'b0, base, '0, 1, 0, 1'b0, "kill_drain");
    // Beat 2 is now outstanding; kill it while the bus stays silent.
    kill = 1'b1; req = 1'b0;
    @(negedge clk);
    kill = 1'b0;
    exp_o = {1'b1, 1'b0, base + 32'h8, 32'h0, 1'b0};
    for (int c = 0; c < 3; c++) begin
      n_run++;
      if ({bus_req_o, bus_wr_o, bus_addr_o, 32'h0, mem2dcache_ack_o} !== exp_o) begin
        n_fail++;
        $display("FAIL kill_drain hold cyc%0d: got req=%b addr=%h ack=%b expected req=1 addr=%h ack=0",
                 c, bus_req_o, bus_addr_o, mem2dcache_ack_o, base + 32'h8);
      end
      @(negedge clk);
    end
    bus_ack = 1'b1; bus_rdata = ~mem_read(base + 32'h8);
    @(negedge clk);
    bus_ack = 1'b0;
    exp_r = {1'b0, 1'b0, model_data};
    for (int c = 0; c < 3; c++) begin
      n_run++;
      if ({bus_req_o, mem2dcache_ack_o, mem2dcache_data_o} !== exp_r) begin
        n_fail++;
        $display("FAIL kill_drain after cyc%0d {bus_req,ack,data}: got %h expected %h",
                 c, {bus_req_o, mem2dcache_ack_o, mem2dcache_data_o}, exp_r);
      end
      @(negedge clk);
    end
    n_run++;
    if (ack_pulses !== c0) begin
      n_fail++;
      $display("FAIL kill_drain ack count: got %0d expected 0", ack_pulses - c0);
    end
  endtask

  task automatic test_kill_with_ack();
    int               c0;
    logic [LINE_W-1:0] line;
    c0 = ack_pulses;
    line = {$urandom, $urandom, $urandom, $urandom};
    req = 1'b1; wr = 1'b1; addr = 32'h0000_4000; data = line; kill = 1'b0;
    @(negedge clk);
    drive_beat(1'b1, 32'h0000_4000, line, 0, 1, 1'b0, "kill_ack");
    drive_beat(1'b1, 32'h0000_4000, line, 1, 0, 1'b1, "kill_ack");
    for (int c = 0; c < 3; c++) begin
      n_run++;
      if ({bus_req_o, mem2dcache_ack_o} !== 2'b00) begin
        n_fail++;
        $display("FAIL kill_ack after cyc%0d {bus_req,ack}: got %b expected 00", c, {bus_req_o, mem2dcache_ack_o});
      end
      @(negedge clk);
    end
    n_run++;
    if (ack_pulses !== c0) begin
      n_fail++;
      $display("FAIL kill_ack ack count: got %0d expected 0", ack_pulses - c0);
    end
  endtask

  task automatic test_req_kill_same();
    req = 1'b1; kill = 1'b1; wr = 1'($urandom_range(0, 1)); addr = 32'h0000_5000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_run++;
      if ({bus_req_o, mem2dcache_ack_o} !== 2'b00) begin
        n_fail++;
        $display("FAIL req_kill cyc%0d {bus_req,ack}: got %b expected 00", c, {bus_req_o, mem2dcache_ack_o});
      end
    end
    req = 1'b0; kill = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    req = 1'b1; wr = 1'b0; addr = 32'h0000_6010; kill = 1'b0;
    @(negedge clk);
    drive_beat(1'b0, 32'h0000_6010, '0, 0, 0, 1'b0, "arst_pre");
    #2 rst_n = 1'b0;
    #1;
    n_run++;
    if ({mem2dcache_ack_o, mem2dcache_data_o, bus_req_o, bus_wr_o, bus_addr_o, bus_wdata_o} !== '0) begin
      n_fail++;
      $display("FAIL async reset outputs: got ack=%b data=%h req=%b addr=%h expected all 0",
               mem2dcache_ack_o, mem2dcache_data_o, bus_req_o, bus_addr_o);
    end
    model_data = '0;
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_line(1'b0, 32'h0000_6020, '0, -1, 1'b0, 1'b0, "arst_post");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    salt = $urandom;
    test_reset();
    test_refill_directed();
    test_writeback_directed();
    test_random_lines();
    test_back_to_back();
    test_kill_drain();
    test_kill_with_ack();
    test_req_kill_same();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
